// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline sequencer for a 5-stage CPU. Produces the PC and
//               pipe-register load enables and flushes. It handles three
//               events: load-use stalls, taken-branch flushes and
//               data-memory wait states. It also keeps saturating stall and
//               flush counters for performance debug.
// Ports       :
//   clk_i, rst_i       clock, synchronous active-high reset
//   ifid_rs_i/rt_i     source fields of the instruction in IF/ID
//   ifid_uses_rt_i     IF/ID instruction actually reads rt
//   idex_memread_i     ID/EX holds a load
//   idex_rt_i          load destination register in ID/EX
//   branch_taken_i     taken branch resolved in EX/MEM
//   dm_req_i           EX/MEM performs a data-memory access
//   dm_ready_i         data memory completes the access this cycle
//   *_we_o / *_flush_o pipe-register load enables and flushes
//   stall_cnt_o        saturating count of stalled cycles
//   flush_cnt_o        saturating count of taken-branch flushes
//   mem_err_o          sticky memory-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,   // 1..3
    parameter int unsigned MEM_TIMEOUT     = 15   // 1..255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        ifid_uses_rt_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic        branch_taken_i,
    input  logic        dm_req_i,
    input  logic        dm_ready_i,
    output logic        pc_we_o,
    output logic        ifid_we_o,
    output logic        ifid_flush_o,
    output logic        idex_we_o,
    output logic        idex_flush_o,
    output logic        exmem_we_o,
    output logic        exmem_flush_o,
    output logic        memwb_flush_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        mem_err_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Number of additional stall cycles after the cycle that detects the hazard.
    localparam logic [1:0] c_lu_reload = 2'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] c_timeout   = 8'(MEM_TIMEOUT);

    state_t      state_q,     state_d;
    logic [1:0]  lu_cnt_q,    lu_cnt_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        mem_err_q,   mem_err_d;

    logic        w_lu;
    logic        w_wait;
    logic        w_timeout;
    logic [31:0] w_stall_inc;
    logic [15:0] w_flush_inc;
    state_t      w_eff_state;

    // Load-use hazard: a load in EX writes a register the IF/ID instruction reads.
    // Register $0 is hard-wired, so a load to $0 never creates a dependency.
    assign w_lu = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) ||
                   (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    assign w_wait    = dm_req_i && !dm_ready_i;
    assign w_timeout = (wait_cnt_q >= c_timeout);

    // Saturating increments: counters hold at all-ones instead of wrapping.
    assign w_stall_inc = (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;
    assign w_flush_inc = (flush_cnt_q == 16'hFFFF)      ? flush_cnt_q : flush_cnt_q + 16'd1;

    // When a memory wait ends, the current cycle is decoded as if the
    // pipeline were already back in the state it was frozen from.
    always_comb begin
        w_eff_state = state_q;
        if (state_q == ST_MEM_WAIT) begin
            w_eff_state = (lu_cnt_q != 2'd0) ? ST_LU_STALL : ST_RUN;
        end
    end

    always_comb begin
        // Defaults: pipeline advances freely.
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_we_o    = 1'b1;
        exmem_flush_o = 1'b0;
        memwb_flush_o = 1'b0;

        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q;

        if (w_wait && !w_timeout) begin
            // Freeze every stage; MEM/WB gets a bubble so the instruction
            // stuck in MEM is not written back twice.
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            memwb_flush_o = 1'b1;
            state_d       = ST_MEM_WAIT;
            wait_cnt_d    = wait_cnt_q + 8'd1;
            stall_cnt_d   = w_stall_inc;
        end else if (w_wait) begin
            // Timeout: let the pipeline go with default outputs and flag it.
            mem_err_d  = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = (lu_cnt_q != 2'd0) ? ST_LU_STALL : ST_RUN;
        end else begin
            wait_cnt_d = 8'd0;
            state_d    = w_eff_state;
            if (branch_taken_i) begin
                // Squash the three younger instructions; a pending load-use
                // stall belonged to a squashed instruction, so drop it.
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
                lu_cnt_d      = 2'd0;
                state_d       = ST_RUN;
                flush_cnt_d   = w_flush_inc;
            end else if (w_eff_state == ST_LU_STALL) begin
                pc_we_o      = 1'b0;
                ifid_we_o    = 1'b0;
                idex_flush_o = 1'b1;
                stall_cnt_d  = w_stall_inc;
                lu_cnt_d     = lu_cnt_q - 2'd1;
                state_d      = (lu_cnt_q <= 2'd1) ? ST_RUN : ST_LU_STALL;
            end else if (w_lu) begin
                pc_we_o      = 1'b0;
                ifid_we_o    = 1'b0;
                idex_flush_o = 1'b1;
                stall_cnt_d  = w_stall_inc;
                if (c_lu_reload != 2'd0) begin
                    lu_cnt_d = c_lu_reload;
                    state_d  = ST_LU_STALL;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= 2'd0;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign mem_err_o   = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench. Two instances share stimulus:
//               u_dut1 uses a 1-cycle load-use stall, u_dut3 a 3-cycle one.
//               Control outputs are packed as
//               {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
//                exmem_we, exmem_flush, memwb_flush}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] c_run    = 8'b1101_0100;
    localparam logic [7:0] c_lu     = 8'b0001_1100;
    localparam logic [7:0] c_branch = 8'b1111_1110;
    localparam logic [7:0] c_freeze = 8'b0000_0001;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  ifid_rs_i, ifid_rt_i, idex_rt_i;
    logic        ifid_uses_rt_i, idex_memread_i, branch_taken_i, dm_req_i, dm_ready_i;

    logic        pc_we1, ifid_we1, ifid_fl1, idex_we1, idex_fl1, exmem_we1, exmem_fl1, memwb_fl1, err1;
    logic        pc_we3, ifid_we3, ifid_fl3, idex_we3, idex_fl3, exmem_we3, exmem_fl3, memwb_fl3, err3;
    logic [31:0] stall1, stall3;
    logic [15:0] flush1, flush3;
    logic [7:0]  ctrl1, ctrl3;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(15)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_uses_rt_i(ifid_uses_rt_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .dm_req_i(dm_req_i), .dm_ready_i(dm_ready_i),
        .pc_we_o(pc_we1), .ifid_we_o(ifid_we1), .ifid_flush_o(ifid_fl1),
        .idex_we_o(idex_we1), .idex_flush_o(idex_fl1), .exmem_we_o(exmem_we1),
        .exmem_flush_o(exmem_fl1), .memwb_flush_o(memwb_fl1),
        .stall_cnt_o(stall1), .flush_cnt_o(flush1), .mem_err_o(err1)
    );

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(15)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_uses_rt_i(ifid_uses_rt_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .dm_req_i(dm_req_i), .dm_ready_i(dm_ready_i),
        .pc_we_o(pc_we3), .ifid_we_o(ifid_we3), .ifid_flush_o(ifid_fl3),
        .idex_we_o(idex_we3), .idex_flush_o(idex_fl3), .exmem_we_o(exmem_we3),
        .exmem_flush_o(exmem_fl3), .memwb_flush_o(memwb_fl3),
        .stall_cnt_o(stall3), .flush_cnt_o(flush3), .mem_err_o(err3)
    );

    assign ctrl1 = {pc_we1, ifid_we1, ifid_fl1, idex_we1, idex_fl1, exmem_we1, exmem_fl1, memwb_fl1};
    assign ctrl3 = {pc_we3, ifid_we3, ifid_fl3, idex_we3, idex_fl3, exmem_we3, exmem_fl3, memwb_fl3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs_i      = 5'd0;
        ifid_rt_i      = 5'd0;
        ifid_uses_rt_i = 1'b0;
        idex_memread_i = 1'b0;
        idex_rt_i      = 5'd0;
        branch_taken_i = 1'b0;
        dm_req_i       = 1'b0;
        dm_ready_i     = 1'b0;
    endtask

    // lw $2 followed by add $3,$2,$4
    task automatic set_lw_add();
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd2;
        ifid_rs_i      = 5'd2;
        ifid_rt_i      = 5'd4;
        ifid_uses_rt_i = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("reset_ctrl1", 32'(ctrl1), 32'(c_run));
        chk("reset_stall1", stall1, 32'd0);
        chk("reset_flush1", 32'(flush1), 32'd0);
        chk("reset_err1", 32'(err1), 32'd0);

        // Load-use, 1-cycle and 3-cycle variants
        set_lw_add();
        #1;
        chk("lu_ctrl1", 32'(ctrl1), 32'(c_lu));
        chk("lu_ctrl3", 32'(ctrl3), 32'(c_lu));
        tick();
        clear_inputs();
        #1;
        chk("lu1_done_ctrl", 32'(ctrl1), 32'(c_run));
        chk("lu1_stall", stall1, 32'd1);
        chk("lu3_c2_ctrl", 32'(ctrl3), 32'(c_lu));
        tick();
        chk("lu3_c3_ctrl", 32'(ctrl3), 32'(c_lu));
        chk("lu3_c3_stall", stall3, 32'd2);
        tick();
        chk("lu3_done_ctrl", 32'(ctrl3), 32'(c_run));
        chk("lu3_stall", stall3, 32'd3);
        chk("lu1_stall_hold", stall1, 32'd1);

        // rt dependency only counts when the instruction reads rt
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd5;
        ifid_rs_i      = 5'd1;
        ifid_rt_i      = 5'd5;
        ifid_uses_rt_i = 1'b0;
        #1;
        chk("rt_unused_ctrl", 32'(ctrl1), 32'(c_run));
        ifid_uses_rt_i = 1'b1;
        #1;
        chk("rt_used_ctrl", 32'(ctrl1), 32'(c_lu));
        // A load to $0 never stalls
        idex_rt_i = 5'd0;
        ifid_rs_i = 5'd0;
        ifid_rt_i = 5'd0;
        #1;
        chk("lw_r0_ctrl", 32'(ctrl1), 32'(c_run));
        clear_inputs();
        #1;

        // Taken branch
        branch_taken_i = 1'b1;
        #1;
        chk("br_ctrl1", 32'(ctrl1), 32'(c_branch));
        chk("br_ctrl3", 32'(ctrl3), 32'(c_branch));
        tick();
        clear_inputs();
        #1;
        chk("br_flush1", 32'(flush1), 32'd1);
        chk("br_after_ctrl1", 32'(ctrl1), 32'(c_run));

        // Branch during LU_STALL cancels the stall
        set_lw_add();
        #1;
        tick();
        clear_inputs();
        #1;
        chk("lu3_pending_ctrl", 32'(ctrl3), 32'(c_lu));
        branch_taken_i = 1'b1;
        #1;
        chk("br_in_lu_ctrl3", 32'(ctrl3), 32'(c_branch));
        tick();
        clear_inputs();
        #1;
        chk("br_cancel_ctrl3", 32'(ctrl3), 32'(c_run));
        chk("br_cancel_flush3", 32'(flush3), 32'd2);
        chk("br_cancel_stall3", stall3, 32'd4);
        chk("stall1_after", stall1, 32'd2);

        // Priority: branch over load-use, wait over branch
        set_lw_add();
        branch_taken_i = 1'b1;
        #1;
        chk("prio_br_lu", 32'(ctrl1), 32'(c_branch));
        dm_req_i   = 1'b1;
        dm_ready_i = 1'b0;
        #1;
        chk("prio_wait_br", 32'(ctrl1), 32'(c_freeze));
        clear_inputs();
        #1;

        // Memory wait of four cycles
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        dm_req_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wait4_ctrl_%0d", i), 32'(ctrl1), 32'(c_freeze));
            tick();
        end
        dm_ready_i = 1'b1;
        #1;
        chk("wait4_release_ctrl", 32'(ctrl1), 32'(c_run));
        chk("wait4_stall", stall1, 32'd4);
        chk("wait4_err", 32'(err1), 32'd0);
        tick();
        clear_inputs();

        // Memory timeout
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        dm_req_i = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_freeze_%0d", i), 32'(ctrl1), 32'(c_freeze));
            tick();
        end
        chk("to_release_ctrl", 32'(ctrl1), 32'(c_run));
        chk("to_stall", stall1, 32'd15);
        chk("to_err_before", 32'(err1), 32'd0);
        tick();
        chk("to_err_set", 32'(err1), 32'd1);
        chk("to_refreeze_ctrl", 32'(ctrl1), 32'(c_freeze));
        repeat (7) tick();
        chk("to_err_sticky", 32'(err1), 32'd1);
        chk("to_stall_22", stall1, 32'd22);

        // Reset while frozen in MEM_WAIT
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        clear_inputs();
        #1;
        chk("rst_wait_ctrl", 32'(ctrl1), 32'(c_run));
        chk("rst_wait_stall", stall1, 32'd0);
        chk("rst_wait_flush", 32'(flush1), 32'd0);
        chk("rst_wait_err", 32'(err1), 32'd0);
        chk("rst_wait_err3", 32'(err3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
